march_cm_bist_ctrl: RTL and testbench
=====================================

Name: march_cm_bist_ctrl

Overview:
- MBIST controller sitting directly upstream of the 4096x32 single-port SRAM (RA1SHD and its fault-injection wrapper).
- Drives CEN/WEN/A/D/OEN with a March C- sequence and checks read data returned on Q.
- Reports pass/fail, the first failing address, the march element and a bit syndrome to the test access logic.
- One memory operation is issued per cycle; read compare is pipelined one cycle behind issue.

Parameters:
- ADDR_W, 12, memory address width; N = 2^ADDR_W words.
- DATA_W, 32, memory data width.
- BG, 32'h0000_0000, background pattern. "0" writes BG; "1" writes ~BG.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous active-high reset.
- start  in  1  single-cycle request; honoured only in IDLE.
- CEN  out  1  memory chip enable, active low.
- WEN  out  1  memory write enable, active low.
- A  out  ADDR_W  memory address.
- D  out  DATA_W  memory write data.
- OEN  out  1  memory output enable, active low; held 0.
- Q  in  DATA_W  memory read data, valid the cycle after a read edge.
- busy  out  1  high from start acceptance until done rises.
- done  out  1  test complete; sticky until next accepted start or RST.
- fail  out  1  sticky; at least one miscompare seen.
- fail_addr  out  ADDR_W  address of the first miscompare.
- fail_elem  out  3  march element (0-5) of the first miscompare.
- fail_syn  out  DATA_W  Q XOR expected, for the first miscompare.

Behaviour:
- Reset (RST=1 at an edge): state=IDLE, CEN=1, WEN=1, A=0, D=0, OEN=0, busy=0, done=0, fail=0, fail_addr=0, fail_elem=0, fail_syn=0, compare pipeline invalid.
  - RST wins over start.
  - RST mid-test aborts immediately; no partial result is retained.
- States: IDLE, M0..M5, DRAIN, DONE.
- Elements (per address, ops issued in order, one per cycle):
  - M0 up: w0
  - M1 up: r0, w1
  - M2 up: r1, w0
  - M3 down: r0, w1
  - M4 down: r1, w0
  - M5 up: r0
- Address order: up runs 0..N-1; down runs N-1..0.
  - Element advance happens on the last op at the terminal address.
  - The address counter reloads to 0 or N-1 for the next element; no wrap-around is ever issued.
- Issue encoding:
  - Write: CEN=0, WEN=0, D=pattern.
  - Read: CEN=0, WEN=1, D=0.
  - Idle cycles: CEN=1, WEN=1.
- Compare pipeline:
  - A read issued in cycle k registers exp_valid=1, exp=pattern, exp_addr=A, exp_elem for cycle k+1.
  - At the end of cycle k+1, Q is compared with exp.
  - On mismatch: fail<=1. If fail was 0, capture fail_addr, fail_elem and fail_syn=Q^exp.
  - Later miscompares do not overwrite the captured values.
- start in IDLE or DONE:
  - Clears done, fail and the capture registers.
  - busy<=1, enter M0 at A=0.
  - The first op is presented in the cycle after the start edge.
- start while busy: ignored.
- After the last M5 read the block enters DRAIN for one cycle with CEN=1, so the final compare completes. Then DONE: done=1, busy=0.
- Latency: ops occupy 10N cycles. done is first high 10N+2 cycles after the start edge (N=4096: 40962).
- Width rules: address counter is ADDR_W bits. Element index is 3 bits; values 6-7 are unreachable and return to IDLE.

Test Plan:
- Fault-free memory, start pulse -> busy for 40962 cycles. Then done=1, fail=0, fail_addr=0, fail_syn=0. Exactly 10*4096 CEN=0 cycles.
- Memory wrapper with stuck-at-0 at addr 0x7FB bit 28 -> fail=1, fail_elem=2 (first r1 read), fail_addr=0x7FB, fail_syn=32'h1000_0000. done still rises at cycle 40962.
- Stuck-at-1 at addr 0x000 bit 0 -> fail_elem=1, fail_addr=0x000, fail_syn=32'h0000_0001. Later miscompares in M3/M5 do not change the captured values.
- Protocol check on ops: M3 issues A=0xFFF first and 0x000 last. M0 keeps WEN=0 and D=BG for 4096 consecutive cycles. No write ever precedes a same-element read at the same address.
- RST asserted during M2, together with a start pulse -> next cycle all outputs are at reset values and state is IDLE. A new start then runs the full 40962-cycle test cleanly.
- start re-pulsed while busy -> ignored, busy unchanged, done timing unchanged. start in DONE -> done and fail clear the next cycle and the test restarts.

Source files
------------

// File: rtl/march_cm_bist_ctrl_if.sv
// Bundle between the March C- BIST controller and its surroundings: the SRAM
// port (CEN/WEN/A/D/OEN/Q) plus the test-access handshake and result fields.
interface march_cm_bist_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // test access side
  logic              start;
  logic              busy;
  logic              done;
  logic              fail;
  logic [ADDR_W-1:0] fail_addr;
  logic [2:0]        fail_elem;
  logic [DATA_W-1:0] fail_syn;
  // memory side
  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] D;
  logic [DATA_W-1:0] Q;

  // The BIST controller drives the memory pins and reports results.
  modport master (
    input  start, Q,
    output CEN, WEN, OEN, A, D,
    output busy, done, fail, fail_addr, fail_elem, fail_syn
  );

  // Memory plus test-access logic seen from the other end.
  modport slave (
    output start, Q,
    input  CEN, WEN, OEN, A, D,
    input  busy, done, fail, fail_addr, fail_elem, fail_syn
  );
endinterface

// File: rtl/march_cm_bist_ctrl.sv
// March C- memory BIST controller for a single-port SRAM.
// One memory op per cycle; a read's data is compared one cycle after the
// memory samples it. First miscompare (address, element, syndrome) is kept.
module march_cm_bist_ctrl #(
  parameter int                ADDR_W = 12,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}}
) (
  input logic                  CLK,
  input logic                  RST,
  march_cm_bist_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_M0    = 4'd1,
    ST_M1    = 4'd2,
    ST_M2    = 4'd3,
    ST_M3    = 4'd4,
    ST_M4    = 4'd5,
    ST_M5    = 4'd6,
    ST_DRAIN = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LO  = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_HI  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_Z   = {DATA_W{1'b0}};

  // Elements M3 and M4 walk the address space downwards.
  function automatic logic is_down(input state_t s);
    return (s == ST_M3) || (s == ST_M4);
  endfunction

  // Elements M1..M4 perform a read then a write at every address.
  function automatic logic two_op(input state_t s);
    return (s == ST_M1) || (s == ST_M2) || (s == ST_M3) || (s == ST_M4);
  endfunction

  // Element sequencing; M5 hands over to the drain cycle.
  function automatic state_t next_elem(input state_t s);
    case (s)
      ST_M0:   return ST_M1;
      ST_M1:   return ST_M2;
      ST_M2:   return ST_M3;
      ST_M3:   return ST_M4;
      ST_M4:   return ST_M5;
      ST_M5:   return ST_DRAIN;
      default: return ST_IDLE;
    endcase
  endfunction

  // March element number reported in fail_elem.
  function automatic logic [2:0] elem_of(input state_t s);
    case (s)
      ST_M0:   return 3'd0;
      ST_M1:   return 3'd1;
      ST_M2:   return 3'd2;
      ST_M3:   return 3'd3;
      ST_M4:   return 3'd4;
      ST_M5:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  state_t              state_r, state_nxt_s, elem_nxt_s;
  logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
  logic                phase_r, phase_nxt_s;
  logic                start_acc_s, last_op_s, term_s;

  logic                cen_nxt_s, wen_nxt_s;
  logic [DATA_W-1:0]   d_nxt_s, rd_exp_nxt_s;

  logic                cen_r, wen_r;
  logic [ADDR_W-1:0]   a_r;
  logic [DATA_W-1:0]   d_r, rd_exp_r;
  logic [2:0]          op_elem_r;
  logic                busy_r, done_r;

  logic                exp_valid_r;
  logic [DATA_W-1:0]   exp_r;
  logic [ADDR_W-1:0]   exp_addr_r;
  logic [2:0]          exp_elem_r;
  logic                miscmp_s;

  logic                fail_r;
  logic [ADDR_W-1:0]   fail_addr_r;
  logic [2:0]          fail_elem_r;
  logic [DATA_W-1:0]   fail_syn_r;

  // Next state, address and read/write phase of the march walk.
  always_comb begin
    state_nxt_s = state_r;
    addr_nxt_s  = addr_r;
    phase_nxt_s = phase_r;
    start_acc_s = 1'b0;
    last_op_s   = 1'b0;
    term_s      = 1'b0;
    elem_nxt_s  = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          start_acc_s = 1'b1;
          state_nxt_s = ST_M0;
          addr_nxt_s  = ADDR_LO;
          phase_nxt_s = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_M0, ST_M1, ST_M2, ST_M3, ST_M4, ST_M5: begin
        last_op_s  = two_op(state_r) ? phase_r : 1'b1;
        term_s     = is_down(state_r) ? (addr_r == ADDR_LO) : (addr_r == ADDR_HI);
        elem_nxt_s = next_elem(state_r);
        if (!last_op_s) begin
          phase_nxt_s = 1'b1;
        end else if (!term_s) begin
          phase_nxt_s = 1'b0;
          addr_nxt_s  = is_down(state_r) ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        end else begin
          // last op at the terminal address: reload for the next element
          phase_nxt_s = 1'b0;
          state_nxt_s = elem_nxt_s;
          addr_nxt_s  = is_down(elem_nxt_s) ? ADDR_HI : ADDR_LO;
        end
      end
      ST_DRAIN: begin
        state_nxt_s = ST_DONE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        addr_nxt_s  = ADDR_LO;
        phase_nxt_s = 1'b0;
      end
    endcase
  end

  // Memory op for the upcoming cycle, decoded from the next walk position.
  always_comb begin
    cen_nxt_s    = 1'b1;
    wen_nxt_s    = 1'b1;
    d_nxt_s      = DATA_Z;
    rd_exp_nxt_s = DATA_Z;
    case (state_nxt_s)
      ST_M0: begin
        cen_nxt_s = 1'b0;
        wen_nxt_s = 1'b0;
        d_nxt_s   = BG;
      end
      ST_M1, ST_M3: begin
        cen_nxt_s = 1'b0;
        if (phase_nxt_s) begin
          wen_nxt_s = 1'b0;
          d_nxt_s   = ~BG;
        end else begin
          rd_exp_nxt_s = BG;
        end
      end
      ST_M2, ST_M4: begin
        cen_nxt_s = 1'b0;
        if (phase_nxt_s) begin
          wen_nxt_s = 1'b0;
          d_nxt_s   = BG;
        end else begin
          rd_exp_nxt_s = ~BG;
        end
      end
      ST_M5: begin
        cen_nxt_s    = 1'b0;
        rd_exp_nxt_s = BG;
      end
      default: begin
        cen_nxt_s    = 1'b1;
        wen_nxt_s    = 1'b1;
        d_nxt_s      = DATA_Z;
        rd_exp_nxt_s = DATA_Z;
      end
    endcase
  end

  // State register and registered memory pins / status flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      addr_r    <= ADDR_LO;
      phase_r   <= 1'b0;
      cen_r     <= 1'b1;
      wen_r     <= 1'b1;
      a_r       <= ADDR_LO;
      d_r       <= DATA_Z;
      rd_exp_r  <= DATA_Z;
      op_elem_r <= 3'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      addr_r    <= addr_nxt_s;
      phase_r   <= phase_nxt_s;
      cen_r     <= cen_nxt_s;
      wen_r     <= wen_nxt_s;
      a_r       <= addr_nxt_s;
      d_r       <= d_nxt_s;
      rd_exp_r  <= rd_exp_nxt_s;
      op_elem_r <= elem_of(state_nxt_s);
      busy_r    <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      done_r    <= (state_nxt_s == ST_DONE);
    end
  end

  // Compare pipeline: what the read issued last cycle must return now.
  always_ff @(posedge CLK) begin
    if (RST) begin
      exp_valid_r <= 1'b0;
      exp_r       <= DATA_Z;
      exp_addr_r  <= ADDR_LO;
      exp_elem_r  <= 3'd0;
    end else begin
      exp_valid_r <= ~cen_r & wen_r;
      exp_r       <= rd_exp_r;
      exp_addr_r  <= a_r;
      exp_elem_r  <= op_elem_r;
    end
  end

  assign miscmp_s = exp_valid_r && (bus.Q != exp_r);

  // Sticky fail flag; only the first miscompare is captured.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fail_r      <= 1'b0;
      fail_addr_r <= ADDR_LO;
      fail_elem_r <= 3'd0;
      fail_syn_r  <= DATA_Z;
    end else if (start_acc_s) begin
      fail_r      <= 1'b0;
      fail_addr_r <= ADDR_LO;
      fail_elem_r <= 3'd0;
      fail_syn_r  <= DATA_Z;
    end else if (miscmp_s) begin
      fail_r <= 1'b1;
      if (!fail_r) begin
        fail_addr_r <= exp_addr_r;
        fail_elem_r <= exp_elem_r;
        fail_syn_r  <= bus.Q ^ exp_r;
      end
    end
  end

  assign bus.CEN       = cen_r;
  assign bus.WEN       = wen_r;
  assign bus.OEN       = 1'b0;
  assign bus.A         = a_r;
  assign bus.D         = d_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.fail      = fail_r;
  assign bus.fail_addr = fail_addr_r;
  assign bus.fail_elem = fail_elem_r;
  assign bus.fail_syn  = fail_syn_r;

endmodule

// File: tb/tb_march_cm_bist_ctrl.sv
// Bench for march_cm_bist_ctrl on a 16-word memory with stuck-at injection.
// Stimulus pushes expected results into a queue; a monitor checks every
// issued op against an index-based March C- model and pops on done rising.
module tb_march_cm_bist_ctrl;
  localparam int              AW       = 4;
  localparam int              DW       = 32;
  localparam int              NW       = 1 << AW;
  localparam logic [DW-1:0]   BGV      = 32'h0000_0000;
  localparam int              OPS      = 10 * NW;
  localparam int              DONE_REL = 10 * NW + 2;
  localparam int              BUDGET   = 12 * NW + 50;

  typedef struct {
    logic          f;
    logic [AW-1:0] a;
    logic [2:0]    e;
    logic [DW-1:0] s;
    int            sc;
  } exp_t;

  exp_t          sb_q[$];
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic          f_en = 1'b0;
  logic [AW-1:0] f_addr = 4'h0;
  logic [DW-1:0] sa0_m = 32'h0;
  logic [DW-1:0] sa1_m = 32'h0;
  logic [DW-1:0] mem [NW];

  march_cm_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  march_cm_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BG(BGV)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] rd_fault(input logic [DW-1:0] v, input logic [AW-1:0] a);
    if (f_en && (a == f_addr)) return (v & ~sa0_m) | sa1_m;
    return v;
  endfunction

  // Single-port SRAM model: Q registered one cycle after a read edge.
  always @(posedge clk) begin
    if (!bus.CEN) begin
      if (!bus.WEN) mem[bus.A] <= bus.D;
      else          bus.Q <= rd_fault(mem[bus.A], bus.A);
    end
  end

  function automatic logic [63:0] pack_op(input logic b, input logic w,
                                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [63:0] r;
    r = 64'h0;
    r[63]        = 1'b1;
    r[DW+AW+1]   = b;
    r[DW+AW]     = w;
    r[DW+AW-1:DW] = a;
    r[DW-1:0]    = d;
    return r;
  endfunction

  // Expected op number idx of a March C- run (busy, WEN, A, D).
  function automatic logic [63:0] op_model(input int idx);
    int el, j, k, pos, ad;
    logic wr;
    logic [DW-1:0] dat;
    if (idx < NW) begin
      wr = 1'b1; ad = idx; dat = BGV;
    end else if (idx < 9 * NW) begin
      j   = idx - NW;
      el  = 1 + j / (2 * NW);
      k   = j % (2 * NW);
      pos = k / 2;
      wr  = (k % 2) == 1;
      ad  = (el == 3 || el == 4) ? (NW - 1 - pos) : pos;
      if (!wr) dat = 32'h0;
      else     dat = (el == 1 || el == 3) ? ~BGV : BGV;
    end else if (idx < OPS) begin
      wr = 1'b0; ad = idx - 9 * NW; dat = 32'h0;
    end else begin
      return 64'h0;
    end
    return pack_op(1'b1, ~wr, ad[AW-1:0], dat);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: op-by-op protocol check and scoreboard pop on done rising.
  initial begin : monitor
    int   cen_cnt;
    logic done_q;
    exp_t e;
    int   rel;
    cen_cnt = 0;
    done_q  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cen_cnt = 0;
        done_q  = 1'b0;
      end else begin
        if (!bus.CEN) begin
          check($sformatf("op%0d", cen_cnt),
                pack_op(bus.busy, bus.WEN, bus.A, bus.D), op_model(cen_cnt));
          cen_cnt++;
        end
        if (bus.done && !done_q) begin
          check("sb_pending", 64'(sb_q.size() > 0), 64'd1);
          if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            rel = cyc - e.sc + 1;
            check("done_cycle", 64'(rel), 64'(DONE_REL));
            check("cen_ops", 64'(cen_cnt), 64'(OPS));
            check("busy_at_done", 64'(bus.busy), 64'd0);
            check("fail", 64'(bus.fail), 64'(e.f));
            check("fail_addr", 64'(bus.fail_addr), 64'(e.a));
            check("fail_elem", 64'(bus.fail_elem), 64'(e.e));
            check("fail_syn", 64'(bus.fail_syn), 64'(e.s));
          end
          cen_cnt = 0;
        end
        done_q = bus.done;
      end
    end
  end

  task automatic pulse_start(output int sc);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    sc = cyc;
  endtask

  task automatic set_fault(input logic en, input logic [AW-1:0] a,
                           input logic [DW-1:0] m0, input logic [DW-1:0] m1);
    f_en = en; f_addr = a; sa0_m = m0; sa1_m = m1;
  endtask

  task automatic expect_run(input logic f, input logic [AW-1:0] a, input logic [2:0] e,
                            input logic [DW-1:0] s, input int sc);
    exp_t x;
    x.f = f; x.a = a; x.e = e; x.s = s; x.sc = sc;
    sb_q.push_back(x);
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!bus.done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_done_seen"}, 64'(bus.done), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ctrl"}, 64'({bus.CEN, bus.WEN, bus.OEN, bus.busy, bus.done, bus.fail}),
          64'(6'b110000));
    check({tag, "_bus"}, 64'({bus.A, bus.D}), 64'h0);
    check({tag, "_cap"}, 64'({bus.fail_addr, bus.fail_elem, bus.fail_syn}), 64'h0);
  endtask

  initial begin : stim
    int sc;
    bus.start = 1'b1;                    // start held during reset: must be ignored
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("rst_beats_start", 64'(bus.busy), 64'd0);

    // fault-free run with a start re-pulse while busy
    set_fault(1'b0, 4'h0, 32'h0, 32'h0);
    pulse_start(sc);
    expect_run(1'b0, 4'h0, 3'd0, 32'h0, sc);
    repeat (40) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_ignores_start", 64'(bus.busy), 64'd1);
    wait_done("clean");

    // stuck-at-0 at 0xB bit 28: first seen by the M2 r1 read
    set_fault(1'b1, 4'hB, 32'h1000_0000, 32'h0);
    pulse_start(sc);
    expect_run(1'b1, 4'hB, 3'd2, 32'h1000_0000, sc);
    wait_done("sa0_b");

    // stuck-at-1 at 0x0 bit 0, started from DONE with fail set
    set_fault(1'b1, 4'h0, 32'h0, 32'h0000_0001);
    pulse_start(sc);
    check("restart_clears", 64'({bus.done, bus.fail, bus.busy, bus.fail_syn}), 64'({3'b001, 32'h0}));
    expect_run(1'b1, 4'h0, 3'd1, 32'h0000_0001, sc);
    wait_done("sa1_0");

    // stuck-at-1 at 0xA bit 31
    set_fault(1'b1, 4'hA, 32'h0, 32'h8000_0000);
    pulse_start(sc);
    check("restart_clears2", 64'({bus.done, bus.fail, bus.fail_addr}), 64'h0);
    expect_run(1'b1, 4'hA, 3'd1, 32'h8000_0000, sc);
    wait_done("sa1_a");

    // abort inside M2 after a miscompare, RST together with start
    set_fault(1'b1, 4'hB, 32'h1000_0000, 32'h0);
    pulse_start(sc);
    repeat (75) @(negedge clk);
    check("pre_abort_fail", 64'({bus.busy, bus.fail}), 64'(2'b11));
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check_reset_vals("abort");
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'({bus.busy, bus.done, bus.CEN}), 64'(3'b001));

    // clean run after the abort
    set_fault(1'b0, 4'h0, 32'h0, 32'h0);
    pulse_start(sc);
    expect_run(1'b0, 4'h0, 3'd0, 32'h0, sc);
    wait_done("post_abort");

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
